// File: rtl/store_write_buffer.sv
`default_nettype none
// ============================================================================
// Module   : store_write_buffer
// Brief    : In-order FIFO write buffer between the core store port and data
//            memory. Stores are absorbed at core rate, drained over a
//            valid/ready port, and loads that hit a pending store get the
//            youngest matching data forwarded combinationally.
// Revision : 1.0 - initial release
// ============================================================================
module store_write_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    MemWrite,
    input  logic [AW-1:0]           DataAdr,
    input  logic [DW-1:0]           WriteData,
    input  logic [AW-1:0]           LdAdr,
    output logic                    Stall,
    output logic                    LdHit,
    output logic [DW-1:0]           LdData,
    output logic                    MemWValid,
    output logic [AW-1:0]           MemWAdr,
    output logic [DW-1:0]           MemWData,
    input  logic                    MemWReady,
    output logic [$clog2(DEPTH):0]  Count,
    output logic                    Empty
);

    localparam int c_PW = $clog2(DEPTH);
    localparam int c_CW = c_PW + 1;
    localparam logic [c_CW-1:0] c_FULL    = c_CW'(DEPTH);
    localparam logic [c_CW-1:0] c_CNT_ONE = c_CW'(1);
    localparam logic [c_PW-1:0] c_PTR_ONE = c_PW'(1);

    logic [AW-1:0]   r_adr  [DEPTH];
    logic [DW-1:0]   r_data [DEPTH];
    logic [c_PW-1:0] r_rdPtr;
    logic [c_PW-1:0] r_wrPtr;
    logic [c_CW-1:0] r_count;
    logic            w_enq;
    logic            w_deq;
    logic [c_PW-1:0] w_fwdIdx;

    // Memory port is driven from registered state only; no input bypass.
    assign MemWValid = (r_count != '0);
    assign Empty     = (r_count == '0);
    assign MemWAdr   = r_adr[r_rdPtr];
    assign MemWData  = r_data[r_rdPtr];
    assign Count     = r_count;

    // A full buffer still accepts a store when the head drains this cycle,
    // which makes Stall combinational from MemWReady.
    assign w_deq = MemWValid & MemWReady;
    assign w_enq = MemWrite & ((r_count < c_FULL) | w_deq);
    assign Stall = MemWrite & ~w_enq;

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rdPtr <= '0;
            r_wrPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_enq) begin
                r_wrPtr <= r_wrPtr + c_PTR_ONE;
            end
            if (w_deq) begin
                r_rdPtr <= r_rdPtr + c_PTR_ONE;
            end
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage; contents are don't-care after reset so no reset here.
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_adr[r_wrPtr]  <= DataAdr;
            r_data[r_wrPtr] <= WriteData;
        end
    end

    // Forwarding: walk valid entries oldest to youngest so the youngest word
    // match wins. The entry leaving this cycle is still counted as valid.
    always_comb begin
        LdHit    = 1'b0;
        LdData   = '0;
        w_fwdIdx = r_rdPtr;
        for (int k = 0; k < DEPTH; k++) begin
            w_fwdIdx = r_rdPtr + c_PW'(k);
            if ((c_CW'(k) < r_count) &&
                (r_adr[w_fwdIdx][AW-1:2] == LdAdr[AW-1:2])) begin
                LdHit  = 1'b1;
                LdData = r_data[w_fwdIdx];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_store_write_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_store_write_buffer
// Brief    : Self-checking bench for store_write_buffer using a queue-based
//            reference model of the buffer contents and the memory-side log.
// Revision : 1.0 - initial release
// ============================================================================
module tb_store_write_buffer;

    localparam int DEPTH = 4;

    logic        clk;
    logic        reset;
    logic        MemWrite;
    logic [31:0] DataAdr;
    logic [31:0] WriteData;
    logic [31:0] LdAdr;
    logic        Stall;
    logic        LdHit;
    logic [31:0] LdData;
    logic        MemWValid;
    logic [31:0] MemWAdr;
    logic [31:0] MemWData;
    logic        MemWReady;
    logic [2:0]  Count;
    logic        Empty;

    store_write_buffer #(.DEPTH(DEPTH), .AW(32), .DW(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .MemWrite  (MemWrite),
        .DataAdr   (DataAdr),
        .WriteData (WriteData),
        .LdAdr     (LdAdr),
        .Stall     (Stall),
        .LdHit     (LdHit),
        .LdData    (LdData),
        .MemWValid (MemWValid),
        .MemWAdr   (MemWAdr),
        .MemWData  (MemWData),
        .MemWReady (MemWReady),
        .Count     (Count),
        .Empty     (Empty)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } ent_t;

    ent_t q[$];      // model of buffered stores, oldest first
    ent_t wlog[$];   // writes the DUT actually handed to memory
    int   vectors    = 0;
    int   miscompares = 0;
    logic lastStall;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: apply inputs, compare outputs with the model, advance.
    task automatic step(input logic mw, input logic [31:0] adr, input logic [31:0] wd,
                        input logic [31:0] ld, input logic rdy, output logic acc);
        logic        expDeq;
        logic        expEnq;
        logic        expHit;
        logic [31:0] expLd;
        MemWrite  = mw;
        DataAdr   = adr;
        WriteData = wd;
        LdAdr     = ld;
        MemWReady = rdy;
        #1;
        expDeq = (q.size() != 0) && rdy;
        expEnq = mw && ((q.size() < DEPTH) || expDeq);
        expHit = 1'b0;
        expLd  = '0;
        for (int j = q.size() - 1; j >= 0; j--) begin
            if (!expHit && (q[j].a[31:2] == ld[31:2])) begin
                expHit = 1'b1;
                expLd  = q[j].d;
            end
        end
        chk("count",  Count,     q.size());
        chk("empty",  Empty,     q.size() == 0);
        chk("wvalid", MemWValid, q.size() != 0);
        chk("stall",  Stall,     mw && !expEnq);
        chk("ldhit",  LdHit,     expHit);
        chk("lddata", LdData,    expLd);
        if (q.size() != 0) begin
            chk("wadr",  MemWAdr,  q[0].a);
            chk("wdata", MemWData, q[0].d);
        end
        if (MemWValid && MemWReady) wlog.push_back(ent_t'{a: MemWAdr, d: MemWData});
        lastStall = Stall;
        acc = expEnq;
        @(posedge clk);
        if (expDeq) void'(q.pop_front());
        if (expEnq) q.push_back(ent_t'{a: adr, d: wd});
        @(negedge clk);
    endtask

    task automatic drain();
        logic acc;
        int   n = 0;
        while (q.size() != 0 && n < 50) begin
            step(1'b0, 32'd0, 32'd0, 32'd0, 1'b1, acc);
            n++;
        end
        chk("drain_empty", Empty, 1'b1);
    endtask

    initial begin
        logic acc;
        int   tries;
        reset     = 1'b0;
        MemWrite  = 1'b0;
        DataAdr   = '0;
        WriteData = '0;
        LdAdr     = '0;
        MemWReady = 1'b0;
        lastStall = 1'b0;
        #1;
        chk("rst_count",  Count,     3'd0);
        chk("rst_empty",  Empty,     1'b1);
        chk("rst_wvalid", MemWValid, 1'b0);
        chk("rst_stall",  Stall,     1'b0);
        chk("rst_ldhit",  LdHit,     1'b0);
        chk("rst_lddata", LdData,    32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        // First store becomes visible at the memory port one cycle later.
        step(1'b1, 32'd100, 32'd7, 32'd0, 1'b0, acc);
        chk("t1_stall",  lastStall, 1'b0);
        chk("t1_count",  Count,     3'd1);
        chk("t1_wvalid", MemWValid, 1'b1);
        chk("t1_wadr",   MemWAdr,   32'd100);
        chk("t1_wdata",  MemWData,  32'd7);
        drain();

        // Fill, stall on the fifth store, then release with MemWReady.
        for (int i = 0; i < 4; i++) step(1'b1, 32'd96 + 32'(4 * i), 32'(i + 20), 32'd0, 1'b0, acc);
        chk("t2_full", Count, 3'd4);
        step(1'b1, 32'd112, 32'd24, 32'd0, 1'b0, acc);
        chk("t2_stall_full", lastStall, 1'b1);
        chk("t2_count_held", Count, 3'd4);
        step(1'b1, 32'd112, 32'd24, 32'd112, 1'b1, acc);
        chk("t2_stall_rel", lastStall, 1'b0);
        chk("t2_head",      MemWAdr, 32'd100);
        chk("t2_count",     Count, 3'd4);
        drain();

        // Forwarding picks the youngest match and compares whole words.
        step(1'b1, 32'd96, 32'd3, 32'd0, 1'b0, acc);
        step(1'b1, 32'd96, 32'd9, 32'd0, 1'b0, acc);
        step(1'b0, 32'd0, 32'd0, 32'd96, 1'b0, acc);
        chk("t3_hit96",  LdHit,  1'b1);
        chk("t3_data96", LdData, 32'd9);
        step(1'b0, 32'd0, 32'd0, 32'd97, 1'b0, acc);
        chk("t3_hit97",  LdHit,  1'b1);
        step(1'b0, 32'd0, 32'd0, 32'd200, 1'b0, acc);
        chk("t3_hit200",  LdHit,  1'b0);
        chk("t3_data200", LdData, 32'd0);
        drain();

        // 50 stores with random memory backpressure and random load probes.
        wlog.delete();
        for (int i = 0; i < 50; i++) begin
            tries = 0;
            do begin
                step(1'b1, 32'(4 * i), 32'(i),
                     32'(4 * $urandom_range(0, i + 1) + $urandom_range(0, 3)),
                     1'($urandom_range(0, 1)), acc);
                tries++;
            end while (!acc && tries < 100);
            chk("t4_accept", acc, 1'b1);
        end
        drain();
        chk("t4_nwrites", wlog.size(), 50);
        for (int i = 0; i < wlog.size(); i++) begin
            chk("t4_order_adr",  wlog[i].a, 32'(4 * i));
            chk("t4_order_data", wlog[i].d, wlog[i].a >> 2);
        end

        // Asynchronous reset mid-cycle discards everything immediately.
        for (int i = 0; i < 3; i++) step(1'b1, 32'd300 + 32'(4 * i), 32'(i + 1), 32'd0, 1'b0, acc);
        chk("t5_count3", Count, 3'd3);
        MemWrite = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        chk("t5_count0", Count,     3'd0);
        chk("t5_wvalid", MemWValid, 1'b0);
        chk("t5_empty",  Empty,     1'b1);
        q.delete();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        step(1'b1, 32'd100, 32'd7, 32'd0, 1'b0, acc);
        chk("t5_head_adr",  MemWAdr,  32'd100);
        chk("t5_head_data", MemWData, 32'd7);
        chk("t5_count1",    Count,    3'd1);
        drain();

        // Full buffer with simultaneous store and drain across pointer wrap.
        for (int i = 0; i < 4; i++) step(1'b1, 32'd1000 + 32'(4 * i), 32'(i + 40), 32'd0, 1'b0, acc);
        for (int c = 0; c < 2 * DEPTH; c++) begin
            step(1'b1, 32'd2000 + 32'(4 * c), 32'(c + 60), 32'd2000 + 32'(4 * c), 1'b1, acc);
            chk("t6_stall", lastStall, 1'b0);
            chk("t6_count", Count, 3'd4);
        end
        chk("t6_head", MemWAdr, 32'd2016);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
